// File: rtl/id_stage_pipe.sv
// id_stage_pipe: MIPS decode with fixed-priority bypass, load-use bubbles and a registered ID/EX stage.
// Optional: define ID_PERF_CNT_EN to add stall_cnt_o / bubble_cnt_o performance counters.
module id_stage_pipe #(
  parameter int DATA_W  = 32,
  parameter int NUM_FWD = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [31:0]               pc_i,
  input  logic [31:0]               inst_i,
  output logic [4:0]                reg1_addr_o,
  output logic [4:0]                reg2_addr_o,
  input  logic [DATA_W-1:0]         reg1_data_i,
  input  logic [DATA_W-1:0]         reg2_data_i,
  input  logic [NUM_FWD-1:0]        fwd_wreg_i,
  input  logic [5*NUM_FWD-1:0]      fwd_wd_i,
  input  logic [DATA_W*NUM_FWD-1:0] fwd_wdata_i,
  input  logic [NUM_FWD-1:0]        fwd_load_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [31:0]               pc_o,
  output logic [2:0]                alusel_o,
  output logic [7:0]                aluop_o,
  output logic [DATA_W-1:0]         reg1_o,
  output logic [DATA_W-1:0]         reg2_o,
  output logic [4:0]                wd_o,
  output logic                      wreg_o,
  output logic                      is_load_o
`ifdef ID_PERF_CNT_EN
  ,
  output logic [31:0]               stall_cnt_o,
  output logic [31:0]               bubble_cnt_o
`endif
);
  localparam logic [2:0] SEL_NONE  = 3'd0;
  localparam logic [2:0] SEL_LOGIC = 3'd1;
  localparam logic [2:0] SEL_MOVE  = 3'd2;
  localparam logic [2:0] SEL_ARITH = 3'd3;
  localparam logic [2:0] SEL_LOAD  = 3'd4;

  logic [5:0]        w_opcode, w_funct;
  logic [4:0]        w_rs, w_rt, w_rd, w_wd;
  logic [15:0]       w_imm16;
  logic [2:0]        w_alusel;
  logic [7:0]        w_aluop;
  logic              w_re1, w_re2, w_wreg, w_is_load;
  logic [DATA_W-1:0] w_imm, w_byp1, w_byp2, w_op1, w_op2;
  logic              w_lhit1, w_lhit2, w_src1, w_src2, w_stall, w_adv;
  logic              w_unused;

  logic              r_valid, r_wreg, r_is_load;
  logic [31:0]       r_pc;
  logic [2:0]        r_alusel;
  logic [7:0]        r_aluop;
  logic [DATA_W-1:0] r_reg1, r_reg2;
  logic [4:0]        r_wd;

  assign w_opcode = inst_i[31:26];
  assign w_rs     = inst_i[25:21];
  assign w_rt     = inst_i[20:16];
  assign w_rd     = inst_i[15:11];
  assign w_funct  = inst_i[5:0];
  assign w_imm16  = inst_i[15:0];
  assign w_unused = ^inst_i[10:6];

  assign reg1_addr_o = w_rs;
  assign reg2_addr_o = w_rt;

  always_comb begin
    w_alusel  = SEL_NONE;
    w_aluop   = 8'h00;
    w_re1     = 1'b0;
    w_re2     = 1'b0;
    w_wd      = 5'd0;
    w_wreg    = 1'b0;
    w_is_load = 1'b0;
    w_imm     = '0;
    if (w_opcode == 6'b000000) begin
      case (w_funct)
        6'h24, 6'h25, 6'h26, 6'h27: begin
          w_alusel = SEL_LOGIC; w_aluop = {2'b00, w_funct};
          w_re1 = 1'b1; w_re2 = 1'b1; w_wd = w_rd; w_wreg = 1'b1;
        end
        6'h21, 6'h23, 6'h2A: begin
          w_alusel = SEL_ARITH; w_aluop = {2'b00, w_funct};
          w_re1 = 1'b1; w_re2 = 1'b1; w_wd = w_rd; w_wreg = 1'b1;
        end
        6'h10, 6'h12: begin
          w_alusel = SEL_MOVE; w_aluop = {2'b00, w_funct};
          w_wd = w_rd; w_wreg = 1'b1;
        end
        6'h11, 6'h13: begin
          w_alusel = SEL_MOVE; w_aluop = {2'b00, w_funct};
          w_re1 = 1'b1;
        end
        default: ;
      endcase
    end else begin
      case (w_opcode)
        6'h0C, 6'h0D, 6'h0E: begin
          w_alusel = SEL_LOGIC; w_aluop = {2'b01, w_opcode};
          w_re1 = 1'b1; w_imm = DATA_W'(w_imm16); w_wd = w_rt; w_wreg = 1'b1;
        end
        6'h09, 6'h0A: begin
          w_alusel = SEL_ARITH; w_aluop = {2'b01, w_opcode};
          w_re1 = 1'b1; w_imm = {{(DATA_W-16){w_imm16[15]}}, w_imm16};
          w_wd = w_rt; w_wreg = 1'b1;
        end
        6'h0F: begin
          w_alusel = SEL_LOGIC; w_aluop = {2'b01, w_opcode};
          w_imm = DATA_W'({w_imm16, 16'h0000}); w_wd = w_rt; w_wreg = 1'b1;
        end
        6'h23: begin
          w_alusel = SEL_LOAD; w_aluop = {2'b01, w_opcode};
          w_re1 = 1'b1; w_imm = {{(DATA_W-16){w_imm16[15]}}, w_imm16};
          w_wd = w_rt; w_wreg = 1'b1; w_is_load = 1'b1;
        end
        default: ;
      endcase
    end
    if (w_wd == 5'd0) w_wreg = 1'b0;
  end

  // Walk channels from oldest to youngest so the lowest matching index wins the data;
  // the load flag is OR-ed because any pending load on the register must stall.
  always_comb begin
    w_byp1  = reg1_data_i;
    w_byp2  = reg2_data_i;
    w_lhit1 = 1'b0;
    w_lhit2 = 1'b0;
    for (int k = NUM_FWD-1; k >= 0; k--) begin
      if (fwd_wreg_i[k] && (fwd_wd_i[5*k +: 5] == w_rs)) begin
        w_byp1  = fwd_wdata_i[DATA_W*k +: DATA_W];
        w_lhit1 = w_lhit1 | fwd_load_i[k];
      end
      if (fwd_wreg_i[k] && (fwd_wd_i[5*k +: 5] == w_rt)) begin
        w_byp2  = fwd_wdata_i[DATA_W*k +: DATA_W];
        w_lhit2 = w_lhit2 | fwd_load_i[k];
      end
    end
  end

  assign w_src1 = w_re1 && (w_rs != 5'd0);
  assign w_src2 = w_re2 && (w_rt != 5'd0);
  assign w_op1  = w_src1 ? w_byp1 : '0;
  assign w_op2  = !w_re2 ? w_imm : (w_src2 ? w_byp2 : '0);

  assign w_stall = in_valid_i &&
    ((w_src1 && (w_lhit1 || (r_valid && r_is_load && r_wreg && (r_wd == w_rs)))) ||
     (w_src2 && (w_lhit2 || (r_valid && r_is_load && r_wreg && (r_wd == w_rt)))));
  assign w_adv      = !r_valid || out_ready_i;
  assign in_ready_o = w_adv && !w_stall;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // out_valid_o and the payload stay stable while out_ready_i is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0; r_pc <= '0; r_alusel <= '0; r_aluop <= '0;
      r_reg1 <= '0; r_reg2 <= '0; r_wd <= '0; r_wreg <= 1'b0; r_is_load <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_adv) begin
      if (w_stall) begin
        r_valid <= 1'b0; r_pc <= '0; r_alusel <= '0; r_aluop <= '0;
        r_reg1 <= '0; r_reg2 <= '0; r_wd <= '0; r_wreg <= 1'b0; r_is_load <= 1'b0;
      end else if (in_valid_i) begin
        r_valid <= 1'b1; r_pc <= pc_i; r_alusel <= w_alusel; r_aluop <= w_aluop;
        r_reg1 <= w_op1; r_reg2 <= w_op2; r_wd <= w_wd; r_wreg <= w_wreg;
        r_is_load <= w_is_load;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid_o = r_valid;
  assign pc_o        = r_pc;
  assign alusel_o    = r_alusel;
  assign aluop_o     = r_aluop;
  assign reg1_o      = r_reg1;
  assign reg2_o      = r_reg2;
  assign wd_o        = r_wd;
  assign wreg_o      = r_wreg;
  assign is_load_o   = r_is_load;

`ifdef ID_PERF_CNT_EN
  logic [31:0] r_stall_cnt, r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (!flush_i && w_adv && w_stall) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign stall_cnt_o  = r_stall_cnt;
  assign bubble_cnt_o = r_bubble_cnt;
`endif
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: hand-written vectors, a one-entry expected-queue model and a negedge checker.
`timescale 1ns/1ps
module tb_id_stage_pipe;
  localparam int DW = 32;
  localparam int NF = 2;

  logic            clk, rst, flush_i, in_valid_i, in_ready_o;
  logic [31:0]     pc_i, inst_i;
  logic [4:0]      reg1_addr_o, reg2_addr_o;
  logic [DW-1:0]   reg1_data_i, reg2_data_i;
  logic [NF-1:0]   fwd_wreg_i, fwd_load_i;
  logic [5*NF-1:0] fwd_wd_i;
  logic [DW*NF-1:0] fwd_wdata_i;
  logic            out_valid_o, out_ready_i;
  logic [31:0]     pc_o;
  logic [2:0]      alusel_o;
  logic [7:0]      aluop_o;
  logic [DW-1:0]   reg1_o, reg2_o;
  logic [4:0]      wd_o;
  logic            wreg_o, is_load_o;
`ifdef ID_PERF_CNT_EN
  logic [31:0]     stall_cnt_o, bubble_cnt_o;
`endif

  id_stage_pipe #(.DATA_W(DW), .NUM_FWD(NF)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .pc_i(pc_i), .inst_i(inst_i),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i),
    .fwd_wdata_i(fwd_wdata_i), .fwd_load_i(fwd_load_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .pc_o(pc_o), .alusel_o(alusel_o), .aluop_o(aluop_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o),
    .wreg_o(wreg_o), .is_load_o(is_load_o)
`ifdef ID_PERF_CNT_EN
    , .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
`endif
  );

  typedef struct packed {
    logic [31:0]   pc;
    logic [2:0]    alusel;
    logic [7:0]    aluop;
    logic [DW-1:0] reg1;
    logic [DW-1:0] reg2;
    logic [4:0]    wd;
    logic          wreg;
    logic          is_load;
  } pay_t;
  localparam int PW = $bits(pay_t);

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  src1, src2;
    pay_t        exp;
  } vec_t;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_cmp = 0;
  int   n_err = 0;
  vec_t tbl[13];
  vec_t cur;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] inst, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [2:0] sel, input logic [7:0] op, input logic [DW-1:0] r1,
                              input logic [DW-1:0] r2, input logic [4:0] wd, input logic wreg,
                              input logic ld);
    vec_t v;
    v.inst = inst; v.src1 = s1; v.src2 = s2;
    v.exp.pc = 32'h0; v.exp.alusel = sel; v.exp.aluop = op; v.exp.reg1 = r1; v.exp.reg2 = r2;
    v.exp.wd = wd; v.exp.wreg = wreg; v.exp.is_load = ld;
    return v;
  endfunction

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input vec_t v);
    cur        = v;
    inst_i     = v.inst;
    pc_i       = pc_i + 32'd4;
    in_valid_i = 1'b1;
  endtask

  task automatic idle();
    in_valid_i = 1'b0;
  endtask

  task automatic set_fwd(input int k, input logic we, input logic [4:0] wd,
                         input logic [DW-1:0] data, input logic ld);
    fwd_wreg_i[k]           = we;
    fwd_wd_i[5*k +: 5]      = wd;
    fwd_wdata_i[DW*k +: DW] = data;
    fwd_load_i[k]           = ld;
  endtask

  task automatic clear_fwd();
    fwd_wreg_i = '0; fwd_wd_i = '0; fwd_wdata_i = '0; fwd_load_i = '0;
  endtask

  // scoreboard: exp_q holds what the ID/EX register must contain (0 or 1 entries)
  logic [PW-1:0] exp_q[$];
  logic          m_zero = 1'b1;
  int            m_stall_cnt = 0;
  int            m_bubble_cnt = 0;
  pay_t          c_dut, c_exp;
  logic          c_stall, c_adv;

  function automatic logic pending(input logic [4:0] r);
    pay_t p;
    if (r == 5'd0) return 1'b0;
    for (int k = 0; k < NF; k++)
      if (fwd_wreg_i[k] && fwd_load_i[k] && (fwd_wd_i[5*k +: 5] == r)) return 1'b1;
    if (exp_q.size() != 0) begin
      p = pay_t'(exp_q[0]);
      if (p.is_load && p.wreg && (p.wd == r)) return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    c_dut   = {pc_o, alusel_o, aluop_o, reg1_o, reg2_o, wd_o, wreg_o, is_load_o};
    c_stall = in_valid_i && (pending(cur.src1) || pending(cur.src2));
    c_adv   = (exp_q.size() == 0) || out_ready_i;
    chk("out_valid", PW'(out_valid_o), PW'(exp_q.size() != 0));
    chk("in_ready", PW'(in_ready_o), PW'(c_adv && !c_stall));
    if (in_valid_i) chk("rd_addr", PW'({reg1_addr_o, reg2_addr_o}), PW'(inst_i[25:16]));
    if (exp_q.size() != 0) chk("payload", c_dut, exp_q[0]);
    else if (m_zero) chk("zero_payload", c_dut, '0);
`ifdef ID_PERF_CNT_EN
    chk("stall_cnt", PW'(stall_cnt_o), PW'(m_stall_cnt));
    chk("bubble_cnt", PW'(bubble_cnt_o), PW'(m_bubble_cnt));
`endif
    if (rst) begin
      exp_q.delete(); m_zero = 1'b1; m_stall_cnt = 0; m_bubble_cnt = 0;
    end else begin
      if (c_stall) m_stall_cnt++;
      if (flush_i) exp_q.delete();
      else if (c_adv && c_stall) begin
        exp_q.delete(); m_zero = 1'b1; m_bubble_cnt++;
      end else if (c_adv && in_valid_i) begin
        c_exp = cur.exp; c_exp.pc = pc_i;
        exp_q.delete(); exp_q.push_back(c_exp); m_zero = 1'b0;
      end else if (c_adv) exp_q.delete();
    end
  end

  initial begin
    tbl[0]  = mk(32'h34018001, 5'd0,  5'd0, 3'd1, 8'h4D, 32'h0,        32'h00008001, 5'd1,  1'b1, 1'b0); // ORI $1,$0,0x8001
    tbl[1]  = mk(32'h2402FFFF, 5'd0,  5'd0, 3'd3, 8'h49, 32'h0,        32'hFFFFFFFF, 5'd2,  1'b1, 1'b0); // ADDIU $2,$0,-1
    tbl[2]  = mk(32'h3C031234, 5'd0,  5'd0, 3'd1, 8'h4F, 32'h0,        32'h12340000, 5'd3,  1'b1, 1'b0); // LUI $3,0x1234
    tbl[3]  = mk(32'h00A62024, 5'd5,  5'd6, 3'd1, 8'h24, 32'hAA,       32'h22222222, 5'd4,  1'b1, 1'b0); // AND $4,$5,$6
    tbl[4]  = mk(32'h00062024, 5'd0,  5'd6, 3'd1, 8'h24, 32'h0,        32'h22222222, 5'd4,  1'b1, 1'b0); // AND $4,$0,$6
    tbl[5]  = mk(32'h00A64825, 5'd5,  5'd6, 3'd1, 8'h25, 32'h55,       32'h66,       5'd9,  1'b1, 1'b0); // OR $9,$5,$6
    tbl[6]  = mk(32'hFC000000, 5'd0,  5'd0, 3'd0, 8'h00, 32'h0,        32'h0,        5'd0,  1'b0, 1'b0); // unknown
    tbl[7]  = mk(32'h34200005, 5'd1,  5'd0, 3'd1, 8'h4D, 32'h11111111, 32'h5,        5'd0,  1'b0, 1'b0); // ORI $0,$1,5
    tbl[8]  = mk(32'h396AF0F0, 5'd11, 5'd0, 3'd1, 8'h4E, 32'h11111111, 32'h0000F0F0, 5'd10, 1'b1, 1'b0); // XORI
    tbl[9]  = mk(32'h29AC8000, 5'd13, 5'd0, 3'd3, 8'h4A, 32'h11111111, 32'hFFFF8000, 5'd12, 1'b1, 1'b0); // SLTI
    tbl[10] = mk(32'h8C27FFFC, 5'd1,  5'd0, 3'd4, 8'h63, 32'h11111111, 32'hFFFFFFFC, 5'd7,  1'b1, 1'b1); // LW $7,-4($1)
    tbl[11] = mk(32'h00E74021, 5'd7,  5'd7, 3'd3, 8'h21, 32'hDEADBEEF, 32'hDEADBEEF, 5'd8,  1'b1, 1'b0); // ADDU fwd
    tbl[12] = mk(32'h00E74021, 5'd7,  5'd7, 3'd3, 8'h21, 32'h11111111, 32'h22222222, 5'd8,  1'b1, 1'b0); // ADDU regfile
    cur = tbl[6];
    rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    pc_i = 32'h00000FFC; inst_i = 32'h0;
    reg1_data_i = 32'h11111111; reg2_data_i = 32'h22222222;
    clear_fwd();
    cyc(2);
    rst = 1'b0;

    // back-to-back decode, including bypass priority and $0 handling
    drive(tbl[0]); cyc(1);
    chk("ori_valid", PW'(out_valid_o), PW'(1'b1));
    chk("ori_aluop", PW'(aluop_o), PW'(8'h4D));
    chk("ori_reg2", PW'(reg2_o), PW'(32'h00008001));
    drive(tbl[1]); cyc(1);
    chk("addiu_reg2", PW'(reg2_o), PW'(32'hFFFFFFFF));
    drive(tbl[2]); cyc(1);
    chk("lui_reg2", PW'(reg2_o), PW'(32'h12340000));
    set_fwd(0, 1'b1, 5'd5, 32'hAA, 1'b0); set_fwd(1, 1'b1, 5'd5, 32'hBB, 1'b0);
    drive(tbl[3]); cyc(1);
    chk("and_ch0_wins", PW'(reg1_o), PW'(32'hAA));
    set_fwd(0, 1'b1, 5'd0, 32'hCC, 1'b1); set_fwd(1, 1'b0, 5'd0, 32'h0, 1'b0);
    drive(tbl[4]); cyc(1);
    set_fwd(0, 1'b1, 5'd6, 32'h66, 1'b0); set_fwd(1, 1'b1, 5'd5, 32'h55, 1'b0);
    drive(tbl[5]); cyc(1);
    clear_fwd();
    for (int i = 6; i <= 9; i++) begin
      drive(tbl[i]); cyc(1);
    end
    idle(); cyc(1);

    // load-use: one bubble from ID/EX, one from a pending load on channel 0, then bypass
    drive(tbl[10]); cyc(1);
    drive(tbl[11]); cyc(1);
    chk("bubble1_valid", PW'(out_valid_o), PW'(1'b0));
    set_fwd(0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b1); cyc(1);
    set_fwd(0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0); cyc(1);
    chk("addu_fwd_valid", PW'(out_valid_o), PW'(1'b1));
    chk("addu_fwd_reg1", PW'(reg1_o), PW'(32'hDEADBEEF));
`ifdef ID_PERF_CNT_EN
    chk("lu_stall_cnt", PW'(stall_cnt_o), PW'(32'd2));
    chk("lu_bubble_cnt", PW'(bubble_cnt_o), PW'(32'd2));
`endif
    idle(); clear_fwd(); cyc(1);

    // backpressure then flush
    drive(tbl[8]); cyc(1);
    drive(tbl[9]); out_ready_i = 1'b0; cyc(3);
    chk("bp_hold_valid", PW'(out_valid_o), PW'(1'b1));
    chk("bp_hold_reg2", PW'(reg2_o), PW'(32'h0000F0F0));
    flush_i = 1'b1; cyc(1); flush_i = 1'b0;
    chk("flush_valid", PW'(out_valid_o), PW'(1'b0));
    cyc(1);
    out_ready_i = 1'b1; idle(); cyc(2);

    // flush during a load-use stall drops the bubble; the stalled op then issues
    drive(tbl[10]); cyc(1);
    drive(tbl[12]); flush_i = 1'b1; cyc(1); flush_i = 1'b0;
    cyc(1); idle(); cyc(2);

    rst = 1'b1; cyc(1);
`ifdef ID_PERF_CNT_EN
    chk("rst_stall_cnt", PW'(stall_cnt_o), PW'(32'd0));
    chk("rst_bubble_cnt", PW'(bubble_cnt_o), PW'(32'd0));
`endif
    rst = 1'b0; cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised successor to the decode stage: MIPS instruction decode plus a registered ID/EX pipeline register, with valid/ready handshakes on both sides.
- Adds NUM_FWD generic bypass channels with fixed priority, load-use hazard detection with bubble insertion, flush, sign-extended arithmetic immediates and $0 handling.
- Sits between the IF/ID register and EX.

Parameters:
- DATA_W, 32, datapath width (immediates zero/sign-extended to DATA_W).
- NUM_FWD, 2, number of bypass channels; channel 0 is youngest and has highest priority.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush_i  in  1  discard the instruction in ID and the ID/EX register contents.
- in_valid_i  in  1  pc_i/inst_i valid.
- in_ready_o  out  1  ID accepts the instruction this cycle.
- pc_i  in  32  instruction PC.
- inst_i  in  32  instruction word.
- reg1_addr_o  out  5  regfile read address rs = inst_i[25:21], combinational.
- reg2_addr_o  out  5  regfile read address rt = inst_i[20:16], combinational.
- reg1_data_i  in  DATA_W  regfile read data 1.
- reg2_data_i  in  DATA_W  regfile read data 2.
- fwd_wreg_i  in  NUM_FWD  channel k writes a register.
- fwd_wd_i  in  5*NUM_FWD  channel k destination, bits [5k+4:5k].
- fwd_wdata_i  in  DATA_W*NUM_FWD  channel k result.
- fwd_load_i  in  NUM_FWD  channel k result is a load whose data is not yet available.
- out_valid_o  out  1  ID/EX register holds a valid instruction.
- out_ready_i  in  1  EX accepts.
- pc_o  out  32  registered PC.
- alusel_o  out  3  registered unit select: 0 none, 1 Logic, 2 Move, 3 Arith, 4 Load.
- aluop_o  out  8  registered op: special = {2'b00, funct}; I-type = {2'b01, opcode}.
- reg1_o  out  DATA_W  registered operand 1.
- reg2_o  out  DATA_W  registered operand 2 or immediate.
- wd_o  out  5  registered destination.
- wreg_o  out  1  registered write enable.
- is_load_o  out  1  registered: instruction is LW.

Behaviour:
- Reset (sync): out_valid_o=0; pc_o, alusel_o, aluop_o, reg1_o, reg2_o, wd_o, wreg_o, is_load_o all 0.
- Decode set:
  - Special: AND, OR, XOR, NOR, ADDU, SUBU, SLT (read rs+rt, wd=rd); MFHI, MFLO (no read, wd=rd); MTHI, MTLO (read rs, wreg=0).
  - Immediate: ANDI, ORI, XORI zero-extend; ADDIU, SLTI sign-extend; LUI = {imm16, 16'b0}, reads nothing. I-type wd=rt.
  - LW (opcode 100011): alusel 4, reads rs, reg2_o = sign-extended offset, wd=rt, is_load=1.
  - Unknown opcode/funct: alusel 0, aluop 0, wreg 0 (NOP, still valid).
  - wd=0 forces wreg_o=0.
- Operand select, per read port:
  - Not read: operand is imm (port 2) or 0 (port 1).
  - Address 0: operand 0; never forwarded.
  - Otherwise the lowest k with fwd_wreg_i[k] && fwd_wd_i[k]==addr supplies fwd_wdata_i[k].
  - No channel match: regfile data.
- Hazard: stall = in_valid_i && (any read port, addr≠0, matches a channel k with fwd_wreg_i[k] && fwd_load_i[k], OR matches wd_o while out_valid_o && is_load_o && wreg_o).
- Advance: adv = !out_valid_o || out_ready_i.
- in_ready_o = adv && !stall.
- Next-cycle register, in priority order:
  1. rst: reset values.
  2. flush_i: out_valid=0.
  3. adv && stall: bubble, out_valid=0, payload zeroed.
  4. adv && in_valid_i: load decoded payload, out_valid=1.
  5. adv && !in_valid_i: out_valid=0.
  6. Otherwise hold all outputs unchanged (backpressure).
- Latency: one cycle from accept to out_valid_o.
- Stall cycles are unbounded; the stall clears when fwd_load_i deasserts or the matching channel disappears.
- Reset or flush mid-stall: the bubble is dropped; in_ready_o is recomputed from the new state.

Optional Feature:
- ID_PERF_CNT_EN defined: adds outputs stall_cnt_o[31:0] (cycles with in_valid_i && stall) and bubble_cnt_o[31:0] (bubbles inserted).
- Counters wrap at 2^32, clear on rst, and are not cleared by flush.
- Undefined: no counters and no ports.

Test Plan:
- Reset then ORI $1,$0,0x8001 (0x34018001) -> next cycle out_valid=1, alusel=1, aluop=0x4D, reg1=0, reg2=0x00008001, wd=1, wreg=1.
- ADDIU $2,$0,0xFFFF -> reg2=0xFFFFFFFF; LUI $3,0x1234 -> reg2=0x12340000, reg1=0.
- AND $4,$5,$6 with fwd ch0 wd=5 data=0xAA and ch1 wd=5 data=0xBB -> reg1=0xAA (ch0 wins); ch0 wd=0 match on $0 -> reg1=0.
- LW $7,0($1) accepted, then ADDU $8,$7,$7 -> in_ready_o=0 one cycle, bubble (out_valid=0); with fwd_load_i[0]=1 for wd=7 for a further cycle, stall persists; release -> ADDU issues with forwarded data.
- out_ready_i=0 for 3 cycles with valid held -> all outputs stable, in_ready_o=0; flush_i pulse -> out_valid=0 next cycle.
- ID_PERF_CNT_EN: the load-use scenario above -> stall_cnt_o=2, bubble_cnt_o=2; rst -> both 0.
